// File: rtl/exec_stage.sv
// exec_stage: execute stage. A 12-op ALU with {V,C,N,Z} flags and a registered, one-cycle register-file writeback.
// Define EXEC_STAGE_MUL_EN to add opcode 12 (shift-add multiply, bit_width cycles); without it opcode 12 is illegal.
module exec_stage #(
  parameter int bit_width = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           FS,
  input  logic [bit_width-1:0] A,
  input  logic [bit_width-1:0] B,
  input  logic [3:0]           DA_in,
  output logic [bit_width-1:0] D,
  output logic [3:0]           DA,
  output logic                 write,
  output logic                 busy,
  output logic                 err,
  output logic [3:0]           flags
);

  localparam int W = bit_width;

  typedef enum logic [3:0] {
    OP_MOVA = 4'd0,  OP_INC  = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3,
    OP_DEC  = 4'd4,  OP_AND  = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7,
    OP_NOTA = 4'd8,  OP_MOVB = 4'd9,  OP_SHR = 4'd10, OP_SHL = 4'd11,
    OP_MUL  = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1
`ifdef EXEC_STAGE_MUL_EN
    , S_MUL = 2'd2
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     op_q;
  logic [W-1:0]   opa_q, opb_q;
  logic [3:0]     dst_q;
  logic [W-1:0]   d_q;
  logic [3:0]     da_q;
  logic           write_q, err_q;
  logic [3:0]     flags_q;

  logic           op_legal, cap_en, err_d, wb_en;
  logic [W-1:0]   add_b, res;
  logic           add_cin, res_c, res_v;
  logic [W:0]     add_sum;

`ifdef EXEC_STAGE_MUL_EN
  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] prod_q, prod_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     mul_sum;
  logic           mul_done;

  assign op_legal = (FS <= OP_MUL);

  // Right-shifting product: the high half accumulates A, the low half shifts the multiplier out.
  always_comb begin
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    mul_sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opa_q} : {(W+1){1'b0}});
    if (cap_en) begin
      prod_d = {{W{1'b0}}, B};
      cnt_d  = '0;
    end else if (state_q == S_MUL) begin
      prod_d = {mul_sum, prod_q[W-1:1]};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  assign mul_done = (cnt_q == CW'(W - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
      cnt_q  <= '0;
    end else begin
      prod_q <= prod_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  assign op_legal = (FS <= OP_SHL);
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cap_en  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_legal) begin
            cap_en  = 1'b1;
            state_d = S_WB;
`ifdef EXEC_STAGE_MUL_EN
            if (FS == OP_MUL) state_d = S_MUL;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
`ifdef EXEC_STAGE_MUL_EN
      S_MUL:   if (mul_done) state_d = S_WB;
`endif
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wb_en = (state_q == S_WB);

  // One W+1-bit adder serves INC/ADD/SUB/DEC; the top bit is the carry out.
  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case (op_q)
      OP_INC:  add_cin = 1'b1;
      OP_ADD:  add_b   = opb_q;
      OP_SUB:  begin add_b = ~opb_q; add_cin = 1'b1; end
      OP_DEC:  add_b   = '1;
      default: ;
    endcase
    add_sum = {1'b0, opa_q} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_q)
      OP_MOVA: res = opa_q;
      OP_INC, OP_ADD, OP_SUB, OP_DEC: begin
        res   = add_sum[W-1:0];
        res_c = add_sum[W];
        res_v = (opa_q[W-1] == add_b[W-1]) && (add_sum[W-1] != opa_q[W-1]);
      end
      OP_AND:  res = opa_q & opb_q;
      OP_OR:   res = opa_q | opb_q;
      OP_XOR:  res = opa_q ^ opb_q;
      OP_NOTA: res = ~opa_q;
      OP_MOVB: res = opb_q;
      OP_SHR:  begin res = {1'b0, opb_q[W-1:1]}; res_c = opb_q[0];   end
      OP_SHL:  begin res = {opb_q[W-2:0], 1'b0}; res_c = opb_q[W-1]; end
`ifdef EXEC_STAGE_MUL_EN
      OP_MUL:  begin res = prod_q[W-1:0]; res_c = |prod_q[2*W-1:W]; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: operand captures are reset along with the outputs so no X can reach D or flags.
      state_q <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      dst_q   <= '0;
      d_q     <= '0;
      da_q    <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      flags_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      write_q <= wb_en;
      err_q   <= err_d;
      if (cap_en) begin
        op_q  <= FS;
        opa_q <= A;
        opb_q <= B;
        dst_q <= DA_in;
      end
      if (wb_en) begin
        d_q     <= res;
        da_q    <= dst_q;
        flags_q <= {res_v, res_c, res[W-1], (res == '0)};
      end
    end
  end

  assign D     = d_q;
  assign DA    = da_q;
  assign write = write_q;
  assign err   = err_q;
  assign flags = flags_q;
  assign busy  = (state_q != S_IDLE);

endmodule
